// File: rtl/emern_video_timing_gen.sv
// Raster timing generator with a latency-matched sync/blank pipe and registered,
// blank-gated pixel output stage for the display pins.
module emern_video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int COLOR_BITS  = 2,
  parameter int PIX_LATENCY = 1,
  parameter int CNT_W       = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [3*COLOR_BITS-1:0]   pixel_in,
  output logic [CNT_W-1:0]          col,
  output logic [CNT_W-1:0]          row,
  output logic                      active,
  output logic                      load_window,
  output logic                      frame_start,
  output logic [7:0]                frame_count,
  output logic [3*COLOR_BITS-1:0]   rgb_out,
  output logic                      hsync,
  output logic                      vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = 3 * COLOR_BITS;

  // One extra bit so sync end points equal to the total never alias to zero.
  localparam logic [CNT_W:0] H_LAST   = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_LAST   = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] H_VIS    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_VIS    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic           HS_ON    = HSYNC_POL[0];
  localparam logic           VS_ON    = VSYNC_POL[0];

  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic [CNT_W:0]   col_w, row_w, row_next_w;
  logic             h_wrap, v_wrap;
  logic             raw_active, raw_hs, raw_vs;
  logic [2:0]       stage_in, stage_dly;

  logic             load_window_reg;
  logic             frame_start_reg;
  logic [7:0]       frame_count_reg;
  logic [PW-1:0]    rgb_reg;
  logic             hsync_reg, vsync_reg;

  assign col_w      = {1'b0, col_reg};
  assign row_w      = {1'b0, row_reg};
  assign row_next_w = {1'b0, row_next};
  assign h_wrap     = (col_w == H_LAST);
  assign v_wrap     = (row_w == V_LAST);

  assign raw_active = (col_w < H_VIS) && (row_w < V_VIS);
  assign raw_hs     = (col_w >= HS_START) && (col_w < HS_END);
  assign raw_vs     = (row_w >= VS_START) && (row_w < VS_END);

  // A frozen raster feeds blanks into the pipe so the pins go quiet.
  assign stage_in   = en ? {raw_active, raw_hs, raw_vs} : 3'b000;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (en) begin
      if (h_wrap) begin
        col_next = '0;
        row_next = v_wrap ? '0 : row_reg + CNT_W'(1);
      end else begin
        col_next = col_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg         <= '0;
      row_reg         <= '0;
      load_window_reg <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      load_window_reg <= (row_next_w >= V_VIS);
      frame_start_reg <= en && h_wrap && v_wrap;
      if (en && h_wrap && v_wrap) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
    end
  end

  // Delay stages matching the rasteriser latency; zero stages is a straight wire.
  generate
    if (PIX_LATENCY == 0) begin : g_no_pipe
      assign stage_dly = stage_in;
    end else begin : g_pipe
      logic [2:0] pipe_reg [PIX_LATENCY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIX_LATENCY; i++) begin
            pipe_reg[i] <= 3'b000;
          end
        end else begin
          pipe_reg[0] <= stage_in;
          for (int i = 1; i < PIX_LATENCY; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
          end
        end
      end
      assign stage_dly = pipe_reg[PIX_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg   <= '0;
      hsync_reg <= ~HS_ON;
      vsync_reg <= ~VS_ON;
    end else begin
      rgb_reg   <= stage_dly[2] ? pixel_in : '0;
      hsync_reg <= stage_dly[1] ? HS_ON : ~HS_ON;
      vsync_reg <= stage_dly[0] ? VS_ON : ~VS_ON;
    end
  end

  assign col         = col_reg;
  assign row         = row_reg;
  assign active      = raw_active;
  assign load_window = load_window_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;
  assign rgb_out     = rgb_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;

endmodule

// File: tb/tb_emern_video_timing_gen.sv
// Randomised scoreboard bench: a linear-position raster model predicts every output
// each cycle; a monitor compares the DUT against the queued predictions.
module tb_emern_video_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HP = 1, VP = 0;
  localparam int CB = 3, L = 2, CW = 5;
  localparam int PW = 3 * CB;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int TOTAL = HT * VT;

  logic          clk, rst, en;
  logic [PW-1:0] pixel_in;
  logic [CW-1:0] col, row;
  logic          active, load_window, frame_start, hsync, vsync;
  logic [7:0]    frame_count;
  logic [PW-1:0] rgb_out;

  emern_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .COLOR_BITS(CB),
    .PIX_LATENCY(L), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pixel_in(pixel_in),
    .col(col), .row(row), .active(active), .load_window(load_window),
    .frame_start(frame_start), .frame_count(frame_count),
    .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            col;
    int            row;
    bit            act;
    bit            lw;
    bit            fs;
    int            fc;
    logic [PW-1:0] rgb;
    bit            hs;
    bit            vs;
  } exp_t;

  exp_t     exp_q[$];
  bit [2:0] stage_q[$];
  int       m_pos = 0;
  int       m_fc = 0;
  bit       m_fs = 0;
  bit       m_lw = 0;
  int       n_checks = 0;
  int       n_pass = 0;
  bit       done = 0;

  function automatic bit is_vis(int p);
    return (p % HT) < HA && (p / HT) < VA;
  endfunction

  function automatic bit is_hs(int p);
    int c = p % HT;
    return c >= HA + HFP && c < HA + HFP + HS;
  endfunction

  function automatic bit is_vs(int p);
    int r = p / HT;
    return r >= VA + VFP && r < VA + VFP + VS;
  endfunction

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act_v, exp_v, $time);
  endtask

  // Drive one cycle of inputs and queue what the pins must show after the edge.
  task automatic drive(bit r, bit e);
    logic [PW-1:0] pix;
    bit [2:0]      o;
    exp_t          x;
    pix = PW'($urandom);
    rst = r;
    en = e;
    pixel_in = pix;
    stage_q.push_back({e && is_vis(m_pos), e && is_hs(m_pos), e && is_vs(m_pos)});
    o = 3'b000;
    if (r) begin
      m_pos = 0;
      m_fc = 0;
      m_fs = 0;
      m_lw = 0;
      stage_q.delete();
    end else begin
      m_fs = e && (m_pos == TOTAL - 1);
      if (m_fs) m_fc = (m_fc + 1) % 256;
      if (e) m_pos = (m_pos + 1) % TOTAL;
      m_lw = (m_pos / HT) >= VA;
      if (stage_q.size() > L) o = stage_q.pop_front();
    end
    x.col = m_pos % HT;
    x.row = m_pos / HT;
    x.act = is_vis(m_pos);
    x.lw  = m_lw;
    x.fs  = m_fs;
    x.fc  = m_fc;
    x.rgb = o[2] ? pix : '0;
    x.hs  = o[1] ? HP[0] : !HP[0];
    x.vs  = o[0] ? VP[0] : !VP[0];
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: got 0 queued expected 1 at t=%0t", $time);
      end else begin
        x = exp_q.pop_front();
        chk("col", 32'(col), 32'(x.col));
        chk("row", 32'(row), 32'(x.row));
        chk("active", 32'(active), 32'(x.act));
        chk("load_window", 32'(load_window), 32'(x.lw));
        chk("frame_start", 32'(frame_start), 32'(x.fs));
        chk("frame_count", 32'(frame_count), 32'(x.fc));
        chk("rgb_out", 32'(rgb_out), 32'(x.rgb));
        chk("hsync", 32'(hsync), 32'(x.hs));
        chk("vsync", 32'(vsync), 32'(x.vs));
        if (x.fs) $display("frame_start seen, frame_count=%0d t=%0t", frame_count, $time);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    pixel_in = '0;
    repeat (3) drive(1, 0);
    repeat (2 * TOTAL + 5) drive(0, 1);
    // Freeze mid-line inside the visible area, then resume.
    while (m_pos != 2 * HT + 5) drive(0, 1);
    repeat (20) drive(0, 0);
    repeat (30) drive(0, 1);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0);
    end
    // Reset while mid-frame with enable held high.
    while (m_pos != 3 * HT + 6) drive(0, 1);
    drive(1, 1);
    repeat (HT + 3) drive(0, 1);
    // Long enabled run so the frame counter wraps past 255.
    repeat (258 * TOTAL) drive(0, 1);
    done = 1'b1;
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
